// File: rtl/noc_packet_sender.sv
`default_nettype none
// ============================================================================
// Module      : noc_packet_sender
// Description : NoC transmit endpoint. Turns descriptor + payload streams into
//               header/body/tail flits through one registered output slot.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_packet_sender #(
    parameter int          DEST_W         = 8,
    parameter int          LEN_W          = 4,
    parameter logic [7:0]  SRC_ID         = 8'h00,
    parameter int          NOC_DATA_WIDTH = 32
) (
    input  logic                      noc_clk,
    input  logic                      noc_rst,
    input  logic                      pkt_valid,
    output logic                      pkt_ready,
    input  logic [DEST_W-1:0]         pkt_dest,
    input  logic [LEN_W-1:0]          pkt_len,
    input  logic                      pkt_data_valid,
    output logic                      pkt_data_ready,
    input  logic [NOC_DATA_WIDTH-1:0] pkt_data,
    output logic                      sender_valid,
    input  logic                      sender_ready,
    output logic [NOC_DATA_WIDTH-1:0] sender_flit,
    output logic                      sender_is_header,
    output logic                      sender_is_tail,
    output logic [15:0]               tx_pkt_cnt
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BODY = 1'b1;

    logic [0:0]                r_state;
    logic [LEN_W-1:0]          r_remaining;
    logic                      w_slot_free;
    logic                      w_desc_hs;
    logic                      w_data_hs;
    logic [NOC_DATA_WIDTH-1:0] w_header;

    assign w_slot_free    = !sender_valid || sender_ready;
    assign pkt_ready      = (r_state == ST_IDLE) && w_slot_free;
    assign pkt_data_ready = (r_state == ST_BODY) && w_slot_free;
    assign w_desc_hs      = pkt_valid && pkt_ready;
    assign w_data_hs      = pkt_data_valid && pkt_data_ready;

    always_comb begin
        w_header                           = '0;
        w_header[DEST_W-1:0]               = pkt_dest;
        w_header[DEST_W +: LEN_W]          = pkt_len;
        w_header[DEST_W+LEN_W +: 8]        = SRC_ID;
    end

    // The state returns to IDLE as soon as the tail is loaded, so a descriptor
    // can be taken in the same cycle the tail drains.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            r_state          <= ST_IDLE;
            r_remaining      <= '0;
            sender_valid     <= 1'b0;
            sender_flit      <= '0;
            sender_is_header <= 1'b0;
            sender_is_tail   <= 1'b0;
            tx_pkt_cnt       <= 16'h0000;
        end else begin
            if (w_desc_hs) begin
                sender_valid     <= 1'b1;
                sender_flit      <= w_header;
                sender_is_header <= 1'b1;
                sender_is_tail   <= (pkt_len == '0);
                r_remaining      <= pkt_len;
                r_state          <= (pkt_len == '0) ? ST_IDLE : ST_BODY;
            end else if (w_data_hs) begin
                sender_valid     <= 1'b1;
                sender_flit      <= pkt_data;
                sender_is_header <= 1'b0;
                sender_is_tail   <= (r_remaining == LEN_W'(1));
                r_remaining      <= r_remaining - LEN_W'(1);
                if (r_remaining == LEN_W'(1)) begin
                    r_state <= ST_IDLE;
                end
            end else if (sender_ready) begin
                sender_valid <= 1'b0;
            end

            if (sender_valid && sender_ready && sender_is_tail) begin
                tx_pkt_cnt <= tx_pkt_cnt + 16'h0001;
            end
        end
    end

endmodule
`default_nettype wire
